// File: rtl/fetch_pc_unit_if.sv
// Fetch-side handshake bundle: instruction-memory request/response and the
// valid/ready buffer presented to decode.
interface fetch_pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            if_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch, feeding decode through a
// one-entry valid/ready buffer. Redirects flush the buffer and kill in-flight fetches.
module fetch_pc_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_misaligned,
    fetch_pc_unit_if.master bus
);

    typedef enum logic [0:0] {StReq, StWait} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            kill_q;
    logic            if_valid_q;
    logic [XLEN-1:0] if_pc_q;
    logic [XLEN-1:0] if_instr_q;
    logic            misaligned_q;

    logic            req_valid;
    logic            req_fire;
    logic            consume;
    logic            redirect_ok;
    logic [XLEN-1:0] redirect_tgt;

    // A request may only issue when the buffer is empty or draining, so it never overflows.
    assign req_valid    = !reset && (state_q == StReq) && !stall && (!if_valid_q || bus.if_ready);
    assign req_fire     = req_valid && bus.imem_req_ready;
    assign consume      = if_valid_q && bus.if_ready;
    assign redirect_ok  = redirect_valid && !redirect_pc[1];
    assign redirect_tgt = redirect_pc & ~XLEN'(1);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instr       = if_instr_q;
    assign fetch_misaligned   = misaligned_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redirect_valid && redirect_pc[1];
            if (consume) begin
                if_valid_q <= 1'b0;
            end
            if (redirect_ok) begin
                pc_q       <= redirect_tgt;
                if_valid_q <= 1'b0;
                unique case (state_q)
                    StReq: begin
                        // The old-pc request is already in flight; drop its response.
                        if (req_fire) begin
                            state_q <= StWait;
                            kill_q  <= 1'b1;
                        end
                    end
                    StWait: begin
                        if (bus.imem_resp_valid) begin
                            state_q <= StReq;
                            kill_q  <= 1'b0;
                        end else begin
                            kill_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                unique case (state_q)
                    StReq: begin
                        if (req_fire) begin
                            state_q <= StWait;
                        end
                    end
                    StWait: begin
                        if (bus.imem_resp_valid) begin
                            state_q <= StReq;
                            if (kill_q) begin
                                kill_q <= 1'b0;
                            end else begin
                                if_valid_q <= 1'b1;
                                if_pc_q    <= pc_q;
                                if_instr_q <= bus.imem_resp_data;
                                pc_q       <= pc_q + XLEN'(4);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Owns the architectural program counter and the instruction-fetch handshake. It is the stage directly downstream of the jump/branch target logic.
- Consumes the next_pc redirect produced by the Jtype unit (JAL/JALR) and by branch resolution.
- Issues word fetches to instruction memory and presents fetched {pc, instr} pairs to decode through a one-entry valid/ready output buffer.
- At most one fetch is outstanding. Redirects flush the buffer and kill any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, PC and instruction width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall; blocks issue of new fetch requests.
- redirect_valid  input  1  one-cycle pulse requesting a PC change.
- redirect_pc  input  XLEN  target PC (Jtype next_pc or branch target).
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  XLEN  fetch address (word aligned).
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_resp_valid  input  1  fetch data valid. Arrives ≥1 cycle after acceptance.
- imem_resp_data  input  XLEN  fetched instruction word.
- if_valid  output  1  output buffer holds a valid instruction.
- if_pc  output  XLEN  PC of the buffered instruction.
- if_instr  output  XLEN  buffered instruction.
- if_ready  input  1  decode consumes the buffer when if_valid & if_ready.
- fetch_misaligned  output  1  one-cycle pulse when a redirect target has bit[1]=1.

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, state=S_REQ, kill=0.
  - if_valid=0, if_pc=0, if_instr=0, fetch_misaligned=0, imem_req_valid=0.
  - Reset asserted mid-fetch drops the outstanding request. A response arriving in the first cycle after reset is ignored.
- State S_REQ:
  - imem_req_valid=1 when (!stall) & (!if_valid | if_ready), with imem_req_addr=pc.
  - On imem_req_valid & imem_req_ready, go to S_WAIT.
  - Request valid/addr are combinational from registered state and the above inputs. Once asserted, they hold stable until accepted unless a redirect occurs.
- State S_WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with kill=0: if_valid<=1, if_pc<=pc, if_instr<=imem_resp_data, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), go to S_REQ.
  - On imem_resp_valid with kill=1: discard the data, kill<=0, pc unchanged (already redirected), go to S_REQ.
- Output buffer:
  - if_valid clears on if_valid & if_ready unless reloaded in the same cycle; a same-cycle consume and load is legal.
  - The buffer never overflows, since a request issues only if the buffer is free or being drained.
- Redirect (redirect_valid=1), highest priority after reset:
  - Target check: if redirect_pc[1]=1, pulse fetch_misaligned for one cycle and ignore the redirect entirely (no flush). Otherwise pc<={redirect_pc[31:1],1'b0} and if_valid<=0 (flush).
  - In S_WAIT with no response this cycle: kill<=1.
  - In S_WAIT with a response this cycle: the response is discarded, go to S_REQ, kill stays 0.
  - In S_REQ with the request accepted this cycle: the old-pc request is in flight, so go to S_WAIT with kill<=1.
  - In S_REQ with no acceptance: the next request uses the new pc.
- Stall:
  - Suppresses new requests only.
  - An in-flight response still loads the buffer.
  - Redirect overrides stall.
- Latency: request accepted in cycle N, response in cycle N+1 → if_valid=1 in cycle N+2. Steady-state throughput is one instruction per 2 cycles with a 1-cycle memory.

Test Plan:
- Reset with RESET_PC=0, always-ready memory with 1-cycle latency, if_ready=1 → requests at addresses 0, 4, 8. if_pc sequence 0, 4, 8, with if_instr matching memory contents.
- Redirect to 100 (JAL target) asserted while in S_WAIT for pc=8 → response for 8 discarded, never shown on if_valid. Next request addr=100, and if_pc=100 follows.
- Redirect to 213 (bit0 set, JALR) → fetch from 212. Redirect to 214 → fetch_misaligned pulses one cycle, fetch continues sequentially, no flush.
- if_ready=0 for 5 cycles with buffer holding pc=4 → if_pc/if_instr stable, no new request issued. On if_ready=1, the request for pc=8 issues in the same cycle.
- stall=1 and redirect_valid=1 to 64 in the same cycle → pc=64, buffer flushed. Requests resume at addr 64 once stall=0.
- imem_req_ready held low 3 cycles, then reset pulsed mid-S_WAIT → addr stable while unaccepted. After reset, the first request is addr=RESET_PC, and a stale response in the next cycle is ignored.
